// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Build with IFU_MISALIGN_CHECK_EN to trap misaligned redirect targets.
package instr_fetch_pkg;

    localparam logic [31:0] IFU_RESET_PC     = 32'h0000_0000;
    localparam int          INSTR_WORD_BYTES = 4;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch stage bus: imem request/response, redirect and decoder handshake.
// master is the fetch stage side, slave the surrounding pipeline/memory.
interface instr_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_next;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, instr_pc_next,
        input  instr_ready,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, instr_pc_next,
        output instr_ready,
        input  fetch_fault
    );

endinterface

// File: rtl/instr_fetch_buffer.sv
// Synchronous FIFO holding fetched words with their PC.
// Flush wins over push and pop in the same cycle.
module fetch_buffer #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, fetch buffer.
// IFU_MISALIGN_CHECK_EN makes misaligned redirects raise a sticky fault.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);

    localparam int          CW   = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0] STEP = 32'(INSTR_WORD_BYTES);

    logic [31:0]  pc;
    logic [31:0]  resp_pc;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] in_flight_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] buf_count;
    logic [CW:0]   occupied;
    logic          fault;
    logic          req_fire;
    logic          resp_fire;
    logic          drop;
    logic          push;
    logic          pop;
    logic          buf_empty;
    logic [31:0]   target;
    fetch_entry_t  entry;
    fetch_entry_t  head;

    // Credit covers both in-flight and buffered words, so pushes never overflow.
    assign occupied = {1'b0, in_flight} + {1'b0, buf_count};
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && !fault
                              && (occupied < (CW+1)'(BUF_DEPTH));
    assign bus.imem_req_addr  = pc;

    assign req_fire       = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_fire      = bus.imem_resp_valid;
    assign in_flight_next = in_flight + CW'(req_fire) - CW'(resp_fire);

    assign drop  = bus.redirect_valid || fault || (discard != '0);
    assign push  = resp_fire && !drop && !rst;
    assign entry = '{pc: resp_pc, word: bus.imem_resp_data};

    assign bus.instr_valid   = !buf_empty && !bus.redirect_valid;
    assign pop               = bus.instr_valid && bus.instr_ready;
    assign bus.instr         = buf_empty ? '0 : head.word;
    assign bus.instr_pc      = buf_empty ? '0 : head.pc;
    assign bus.instr_pc_next = buf_empty ? '0 : head.pc + STEP;
    assign bus.fetch_fault   = fault;

    assign target = word_align(bus.redirect_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            resp_pc   <= RESET_PC;
            in_flight <= '0;
            discard   <= '0;
        end else begin
            in_flight <= in_flight_next;
            if (bus.redirect_valid) begin
                pc      <= target;
                resp_pc <= target;
                discard <= in_flight_next;
            end else begin
                if (req_fire) pc <= pc + STEP;
                if (push)     resp_pc <= resp_pc + STEP;
                if (resp_fire && discard != '0) discard <= discard - 1'b1;
            end
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            fault <= 1'b0;
        else if (bus.redirect_valid)
            fault <= (bus.redirect_pc[1:0] != 2'b00);
    end
`else
    assign fault = 1'b0;
`endif

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (entry),
        .dout  (head),
        .count (buf_count),
        .empty (buf_empty)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed steps then random traffic vs a stream model.
// Define IFU_MISALIGN_CHECK_EN to also exercise the misalignment fault.
module tb_instr_fetch;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_if ifc();

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    always #5 clk = ~clk;

    int          nchk = 0;
    int          npass = 0;
    int          cyc = 0;
    req_t        pend[$];
    int          buffered = 0;
    logic [31:0] exp_req = RST_PC;
    logic [31:0] exp_pc = RST_PC;
    bit          m_fault = 1'b0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic void chk(input string tag, input logic [31:0] obs,
                                input logic [31:0] expv);
        nchk++;
        assert (obs === expv) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifc.imem_req_ready  = 1'b0;
        ifc.imem_resp_valid = 1'b0;
        ifc.imem_resp_data  = '0;
        ifc.redirect_valid  = 1'b0;
        ifc.redirect_pc     = '0;
        ifc.instr_ready     = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req_valid", ifc.imem_req_valid, 0);
        chk("rst_instr_valid", ifc.instr_valid, 0);
        chk("rst_fault", ifc.fetch_fault, 0);
        chk("rst_instr", ifc.instr, 0);
        chk("rst_instr_pc", ifc.instr_pc, 0);
        chk("rst_pc_next", ifc.instr_pc_next, 0);
        pend.delete();
        buffered = 0;
        exp_req  = RST_PC;
        exp_pc   = RST_PC;
        m_fault  = 1'b0;
    endtask

    // One clock of stimulus; the model predicts every output from the
    // architectural stream: consecutive words from the last target.
    task automatic cycle(input bit rdy, input bit ir, input bit rv,
                         input logic [31:0] rpc, input bit give);
        bit   responding;
        bit   exp_rv;
        bit   exp_iv;
        req_t r;
        @(negedge clk);
        rst = 1'b0;
        ifc.imem_req_ready = rdy;
        ifc.instr_ready    = ir;
        ifc.redirect_valid = rv;
        ifc.redirect_pc    = rpc;
        responding = give && pend.size() > 0 && pend[0].due <= cyc;
        ifc.imem_resp_valid = responding;
        ifc.imem_resp_data  = responding ? memw(pend[0].addr) : $urandom;
        #1;
        exp_rv = !rv && !m_fault && (pend.size() + buffered < DEPTH);
        exp_iv = buffered > 0 && !rv;
        chk("req_valid", ifc.imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", ifc.imem_req_addr, exp_req);
        chk("instr_valid", ifc.instr_valid, exp_iv);
        if (buffered > 0) begin
            chk("instr", ifc.instr, memw(exp_pc));
            chk("instr_pc", ifc.instr_pc, exp_pc);
            chk("instr_pc_next", ifc.instr_pc_next, exp_pc + 32'd4);
        end else begin
            chk("empty_instr", ifc.instr, 0);
            chk("empty_pc", ifc.instr_pc, 0);
            chk("empty_pc_next", ifc.instr_pc_next, 0);
        end
        chk("fetch_fault", ifc.fetch_fault, m_fault);
        chk("credit", (pend.size() + buffered <= DEPTH), 1);
        if (responding) begin
            r = pend.pop_front();
            if (!r.stale && !rv && !m_fault) buffered++;
        end
        if (exp_iv && ir) begin
            buffered--;
            exp_pc += 32'd4;
        end
        if (exp_rv && rdy) begin
            pend.push_back('{addr: exp_req, due: cyc + 1, stale: 1'b0});
            exp_req += 32'd4;
        end
        if (rv) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            buffered = 0;
            exp_req  = rpc & ~32'h3;
            exp_pc   = rpc & ~32'h3;
`ifdef IFU_MISALIGN_CHECK_EN
            m_fault  = (rpc[1:0] != 2'b00);
`endif
        end
        cyc++;
    endtask

    initial begin
        logic [31:0] t;
        do_reset();
        // straight-line fetch, addresses 0, 4, 8, ...
        repeat (12) cycle(1, 1, 0, '0, 1);
        // decoder stalls: credit limits outstanding+buffered to DEPTH
        repeat (8) cycle(1, 0, 0, '0, 1);
        // drain with responses held, leaving two requests in flight
        repeat (3) cycle(1, 1, 0, '0, 0);
        cycle(1, 1, 1, 32'h0000_0100, 0);
        repeat (10) cycle(1, 1, 0, '0, 1);
        // redirect coinciding with a response and a ready decoder
        repeat (3) cycle(1, 0, 0, '0, 0);
        cycle(1, 0, 0, '0, 1);
        cycle(1, 1, 1, 32'h0000_0040, 1);
        repeat (8) cycle(1, 1, 0, '0, 1);
        // pc wrap from the top of the address space
        cycle(1, 1, 1, 32'hFFFF_FFF8, 1);
        repeat (10) cycle(1, 1, 0, '0, 1);
`ifndef IFU_MISALIGN_CHECK_EN
        // misaligned target: low bits are cleared
        cycle(1, 1, 1, 32'h0000_0203, 1);
        repeat (8) cycle(1, 1, 0, '0, 1);
`endif
        // reset in the middle of traffic
        repeat (3) cycle(1, 1, 0, '0, 0);
        do_reset();
        repeat (6) cycle(1, 1, 0, '0, 1);
`ifdef IFU_MISALIGN_CHECK_EN
        cycle(1, 1, 1, 32'h0000_0102, 1);
        repeat (8) cycle(1, 1, 0, '0, 1);
        cycle(1, 1, 1, 32'h0000_0200, 1);
        repeat (8) cycle(1, 1, 0, '0, 1);
`endif
        // random traffic
        repeat (2000) begin
            bit rv;
            rv = ($urandom_range(0, 19) == 0);
            t  = $urandom;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
`ifdef IFU_MISALIGN_CHECK_EN
            if ($urandom_range(0, 3) != 0) t = t & ~32'h3;
`endif
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  rv, t, $urandom_range(0, 2) != 0);
        end
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction decoder. Holds the program counter and issues word-aligned requests to instruction memory over a valid/ready request channel with in-order responses. Buffers returned words in a small FIFO and presents them, with their PC and PC+4, to the decoder over a valid/ready handshake. Accepts redirects (taken branch, JAL/JALR target) from the branch unit, flushing buffered and in-flight fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- BUF_DEPTH, 2, fetch buffer entries; power of two, ≥2; also the maximum in-flight plus buffered requests

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, bits [1:0] always 0
- imem_resp_valid  in  1  response word valid; one per accepted request, in order, ≥1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  load new PC, flush
- redirect_pc  in  32  redirect target
- instr_valid  out  1  instruction available to decoder
- instr_ready  in  1  decoder consumes instruction
- instr  out  32  instruction word
- instr_pc  out  32  PC of instr
- instr_pc_next  out  32  instr_pc + 4, modulo 2^32
- fetch_fault  out  1  sticky misaligned-target flag; constant 0 unless macro enabled

## Operation
- State: pc (next address to request), in_flight counter, discard counter, fetch buffer (word + PC per entry), fault flag. Counter width clog2(BUF_DEPTH+1).
- Request issued when in_flight + buffer_count < BUF_DEPTH, no redirect this cycle, fault clear. imem_req_addr = pc. On accept (valid & ready): pc += 4, in_flight++.
- Response: in_flight--. If discard counter > 0, decrement it and drop the word; else push {word, PC} into buffer. Credit rule guarantees buffer never overflows.
- Output: instr/instr_pc from buffer head; instr_valid = buffer non-empty & !redirect_valid. Pop on instr_valid & instr_ready.
- Redirect: buffer flushed; pc <= redirect_pc with bits [1:0] cleared; discard <= in_flight after this cycle's response is applied (a response arriving in the redirect cycle is dropped). Request and output handshakes are suppressed in the redirect cycle.
- No FSM beyond counters; states implicitly RUN / FAULTED (macro only).
- Reset: pc = RESET_PC, counters 0, buffer empty, fault 0; imem_req_valid = 0, instr_valid = 0, fetch_fault = 0, instr/instr_pc/instr_pc_next = 0 while empty.

## Timing
- First request: cycle after rst deasserts, addr = RESET_PC.
- Response to instr_valid: 1 cycle (word registered in buffer).
- Redirect to new request: next cycle after redirect_valid.
- pc wraps 32'hFFFF_FFFC → 0; instr_pc_next wraps likewise.
- rst mid-operation overrides everything, including redirect; responses for pre-reset requests must not arrive after reset (memory is reset together).
- Simultaneous push and pop with full buffer allowed only because pop occurs; credit rule excludes push-on-full.

## Configuration
- IFU_MISALIGN_CHECK_EN defined: redirect_pc[1:0] ≠ 0 sets fetch_fault, stops new requests, discards all remaining responses until the next aligned redirect, which clears it; reset clears it.
- Not defined: low bits silently cleared, fetch_fault tied 0.

## Structure
- Shared package/enum module: RESET_PC default, INSTR_WORD_BYTES (4), NOP encoding 32'h0000_0013.
- Sub-module fetch_buffer: synchronous FIFO parameterised by depth and width (64: word + PC), push/pop/flush/count.

## Test plan
- Reset, imem ready, 1-cycle response, instr_ready=1 → addrs 0,4,8 in order; instr_pc_next = instr_pc+4.
- instr_ready=0 with BUF_DEPTH=2 → exactly 2 requests outstanding/buffered, imem_req_valid low until pop.
- Redirect to 32'h100 with 2 in flight → both responses dropped, next instr_pc = 32'h100.
- Redirect same cycle as response and instr_ready → response dropped, no pop, no request that cycle.
- pc = 32'hFFFF_FFFC → following request addr 0.
- With IFU_MISALIGN_CHECK_EN, redirect to 32'h102 → fetch_fault=1, no requests; redirect to 32'h200 clears it and fetch resumes.
